control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: ADD_WAIT, default 2, number of EXEC cycles for add/sub (ALU adder delay).
REQ-002 Parameter: LOGIC_WAIT, default 1, number of EXEC cycles for loadi/mov/and/or.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: CLK  input  1  rising-edge clock.
REQ-005 Port: RESET  input  1  synchronous active-high reset.
REQ-006 Port: INSTRUCTION  input  32  fields OP[31:24], DEST[23:16], SRC1[15:8], SRC2/IMM[7:0].
REQ-007 Port: INSTR_VALID  input  1  INSTRUCTION valid this cycle.
REQ-008 Port: INSTR_READY  output  1  unit accepts an instruction this cycle.
REQ-009 Port: PC  output  32  address of the next instruction to fetch.
REQ-010 Port: ALUOP  output  3  ALU SELECT code: 000 forward, 001 add, 010 and, 011 or.
REQ-011 Port: READREG1 / READREG2 / WRITEREG  output  3 each  register addresses, taken from SRC1[2:0], SRC2[2:0], DEST[2:0].
REQ-012 Port: IMMEDIATE  output  8  INSTRUCTION[7:0] of the latched instruction.
REQ-013 Port: IMM_SEL  output  1  1 selects IMMEDIATE as ALU operand 2, 0 selects the register.
REQ-014 Port: NEG_SEL  output  1  1 selects the two's-complement of operand 2 (sub).
REQ-015 Port: WRITEENABLE  output  1  register-file write strobe.
REQ-016 Port: ILLEGAL  output  1  one-cycle pulse for an unknown opcode.

Function
REQ-017 Opcodes: 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or; all others are illegal.
REQ-018 Decode, ALUOP / IMM_SEL / NEG_SEL per opcode: loadi 000/1/0; mov 000/0/0; add 001/0/0; sub 001/0/1; and 010/0/0; or 011/0/0.
REQ-019 States: FETCH, EXEC, WB.
REQ-020 INSTR_READY is 1 only in FETCH.
REQ-021 Handshake: an instruction is accepted on the rising edge where INSTR_READY=1 and INSTR_VALID=1; INSTRUCTION is latched on that edge.
REQ-022 FETCH with INSTR_VALID=0: the unit stays in FETCH with all outputs unchanged.
REQ-023 Legal opcode accepted: next state is EXEC with the wait counter loaded to ADD_WAIT (add/sub) or LOGIC_WAIT (other legal opcodes).
REQ-024 EXEC: the counter decrements every cycle; when the counter equals 1 the unit moves to WB, giving exactly N EXEC cycles.
REQ-025 Illegal opcode accepted: next state is WB directly, with WRITEENABLE=0 and ILLEGAL=1 in that WB cycle.
REQ-026 WB lasts one cycle: WRITEENABLE=1 for legal opcodes; PC increments by 4 (mod 2^32) at the end of WB; next state is FETCH.
REQ-027 Timing: for acceptance at edge t, WRITEENABLE=1 in cycle t+N+1 and INSTR_READY=1 again in cycle t+N+2.
REQ-028 Timing for an illegal opcode accepted at edge t: ILLEGAL=1 in cycle t+1 and INSTR_READY=1 in cycle t+2.
REQ-029 Decode outputs (ALUOP, register addresses, IMMEDIATE, IMM_SEL, NEG_SEL) are registered and stay stable from the first EXEC (or WB) cycle until the next acceptance.
REQ-030 Changes of INSTRUCTION or INSTR_VALID outside FETCH are ignored.
REQ-031 WRITEENABLE and ILLEGAL are never 1 in the same cycle, and are never 1 outside WB.
REQ-032 PC wrap: 0xFFFFFFFC + 4 becomes 0x00000000 with no error indication.

Reset
REQ-033 RESET=1 at a rising edge sets: state FETCH, PC=0, ALUOP=000, all register addresses 0, IMMEDIATE=0, IMM_SEL=0, NEG_SEL=0, WRITEENABLE=0, ILLEGAL=0.
REQ-034 INSTR_READY is 0 while RESET=1 and 1 in the first cycle after RESET falls.
REQ-035 Reset in EXEC or WB aborts the instruction: no WRITEENABLE pulse and no PC increment occur for it.
REQ-036 RESET has priority over a simultaneous handshake; that instruction is not accepted.

Verification
REQ-037 Reset then loadi 0x00040007 (VALID held): ALUOP=000, IMM_SEL=1, WRITEREG=4, IMMEDIATE=0x07; WRITEENABLE=1 two cycles after acceptance; PC becomes 4.
REQ-038 sub 0x03010203 -> ALUOP=001, NEG_SEL=1, READREG1=2, READREG2=3; two EXEC cycles; WRITEENABLE three cycles after acceptance.
REQ-039 Back-to-back and 0x04.. then or 0x05.. with VALID held high -> second acceptance exactly one cycle after the first WB; PC goes 0->4->8.
REQ-040 Opcode 0x07 -> ILLEGAL=1 for one cycle, WRITEENABLE stays 0, PC still +4.
REQ-041 RESET asserted in the second EXEC cycle of add -> no WRITEENABLE pulse, PC=0, INSTR_READY=1 the cycle after RESET falls.
REQ-042 PC preloaded to 0xFFFFFFFC (via 0x3FFFFFFF instructions) -> next WB wraps PC to 0x00000000.

Source files
------------

// File: rtl/control_unit_if.sv
// Instruction handshake and decoded-control bundle of the control unit.
// The unit is the slave; the fetch side/register file is the master.
interface control_unit_if;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] PC;
  logic [2:0]  ALUOP;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [2:0]  WRITEREG;
  logic [7:0]  IMMEDIATE;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic        WRITEENABLE;
  logic        ILLEGAL;

  modport master (
    output INSTRUCTION, INSTR_VALID,
    input  INSTR_READY, PC, ALUOP,
    input  READREG1, READREG2, WRITEREG,
    input  IMMEDIATE, IMM_SEL, NEG_SEL,
    input  WRITEENABLE, ILLEGAL
  );

  modport slave (
    input  INSTRUCTION, INSTR_VALID,
    output INSTR_READY, PC, ALUOP,
    output READREG1, READREG2, WRITEREG,
    output IMMEDIATE, IMM_SEL, NEG_SEL,
    output WRITEENABLE, ILLEGAL
  );
endinterface

// File: rtl/control_unit.sv
// FETCH/EXEC/WB sequencer: latches one instruction, waits a per-opcode
// number of EXEC cycles, then strobes write-back and advances the PC.
module control_unit #(
  parameter int unsigned ADD_WAIT   = 2,
  parameter int unsigned LOGIC_WAIT = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  control_unit_if.slave bus
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    WB
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [31:0] pc_q, pc_nx;

  logic [2:0]  aluop_q, rr1_q, rr2_q, wr_q;
  logic [7:0]  imm_q;
  logic        imm_sel_q, neg_sel_q, ill_q;

  logic [7:0]  op;
  logic        ready, accept;
  logic [2:0]  dec_aluop;
  logic        dec_imm_sel, dec_neg_sel;
  logic        dec_legal, dec_long;
  logic        unused_bits;

  assign op     = bus.INSTRUCTION[31:24];
  assign ready  = (state == FETCH) && !RESET;
  assign accept = ready && bus.INSTR_VALID;

  assign unused_bits = ^{bus.INSTRUCTION[23:19],
                         bus.INSTRUCTION[15:11]};

  always_comb begin
    dec_aluop   = 3'b000;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    dec_legal   = 1'b1;
    dec_long    = 1'b0;
    unique case (op)
      8'h00: dec_imm_sel = 1'b1;
      8'h01: dec_aluop   = 3'b000;
      8'h02: begin
        dec_aluop = 3'b001;
        dec_long  = 1'b1;
      end
      8'h03: begin
        dec_aluop   = 3'b001;
        dec_neg_sel = 1'b1;
        dec_long    = 1'b1;
      end
      8'h04: dec_aluop = 3'b010;
      8'h05: dec_aluop = 3'b011;
      default: dec_legal = 1'b0;
    endcase
  end

  // Unknown opcodes skip EXEC and report in WB.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc_q;
    unique case (state)
      FETCH: begin
        if (accept) begin
          if (dec_legal) begin
            state_nx = EXEC;
            cnt_nx   = dec_long ? 8'(ADD_WAIT)
                                : 8'(LOGIC_WAIT);
          end else begin
            state_nx = WB;
          end
        end
      end
      EXEC: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1)
          state_nx = WB;
      end
      WB: begin
        state_nx = FETCH;
        pc_nx    = pc_q + 32'd4;
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= FETCH;
      cnt   <= 8'd0;
      pc_q  <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pc_q  <= pc_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      aluop_q   <= 3'b000;
      rr1_q     <= 3'd0;
      rr2_q     <= 3'd0;
      wr_q      <= 3'd0;
      imm_q     <= 8'd0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      ill_q     <= 1'b0;
    end else if (accept) begin
      aluop_q   <= dec_aluop;
      rr1_q     <= bus.INSTRUCTION[10:8];
      rr2_q     <= bus.INSTRUCTION[2:0];
      wr_q      <= bus.INSTRUCTION[18:16];
      imm_q     <= bus.INSTRUCTION[7:0];
      imm_sel_q <= dec_imm_sel;
      neg_sel_q <= dec_neg_sel;
      ill_q     <= !dec_legal;
    end
  end

  assign bus.INSTR_READY = ready;
  assign bus.PC          = pc_q;
  assign bus.ALUOP       = aluop_q;
  assign bus.READREG1    = rr1_q;
  assign bus.READREG2    = rr2_q;
  assign bus.WRITEREG    = wr_q;
  assign bus.IMMEDIATE   = imm_q;
  assign bus.IMM_SEL     = imm_sel_q;
  assign bus.NEG_SEL     = neg_sel_q;
  assign bus.WRITEENABLE = (state == WB) && !ill_q;
  assign bus.ILLEGAL     = (state == WB) && ill_q;

endmodule
